if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller for the IF stage. It sequences the PC register by driving its `nxt_pc` input and reading back its current value. It runs a single-outstanding request/grant/response transaction to instruction memory and presents fetched instructions to ID with a valid/stall handshake. Branch redirects from EX and trap redirects are applied with priority, and an in-flight response made stale by a redirect is discarded.

## Interface
- `DATA_WIDTH`, default 32: PC, address and instruction width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `pc_i`  in  DATA_WIDTH  current PC from the PC register (0 after reset).
- `nxt_pc_o`  out  DATA_WIDTH  next PC to the PC register, loaded every clock.
- `trap_i`  in  1  trap redirect request, highest priority.
- `trap_vec_i`  in  DATA_WIDTH  trap target.
- `br_taken_i`  in  1  branch/jump redirect from EX.
- `br_target_i`  in  DATA_WIDTH  branch target.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  DATA_WIDTH  fetch address, equal to `pc_i`.
- `imem_gnt_i`  in  1  request accepted for the address presented this cycle.
- `imem_rvalid_i`  in  1  response valid, no earlier than the cycle after grant.
- `imem_rdata_i`  in  DATA_WIDTH  instruction data.
- `stall_i`  in  1  ID cannot accept this cycle.
- `if_valid_o`  out  1  instruction available to ID.
- `if_pc_o`  out  DATA_WIDTH  PC of the presented instruction.
- `if_instr_o`  out  DATA_WIDTH  presented instruction.

## Operation
- Redirect: `redir = trap_i | br_taken_i`.
  - Target is `trap_vec_i` if `trap_i` is set, else `br_target_i`.
  - Target bits [1:0] are forced to 0.
- `nxt_pc_o` priority:
  1. Redirect target.
  2. `pc_i + 4`, modulo 2^DATA_WIDTH, in the cycle a grant is taken without redirect.
  3. Otherwise `pc_i` (hold).
- State machine, resetting to IDLE:
  - IDLE: `imem_req_o = 0`; go to REQ next cycle, redirect or not.
  - REQ: `imem_req_o = 1`.
    - Grant without redirect: latch `fetch_pc_q <= pc_i`, go to WAIT.
    - Grant with redirect: go to WAIT with `kill_q = 1`.
    - Redirect without grant: stay in REQ; the address changes next cycle, which is legal before grant.
  - WAIT: `imem_req_o = 0`.
    - Redirect in any WAIT cycle, including the `rvalid` cycle, sets `kill_q`.
    - On `rvalid` with `kill_q` or redirect: discard the data, clear `kill_q`, go to REQ.
    - On `rvalid` otherwise: `if_instr_o <= imem_rdata_i`, `if_pc_o <= fetch_pc_q`, `if_valid_o <= 1`, go to OUT.
  - OUT: `if_valid_o = 1`; outputs hold while `stall_i = 1`.
    - Redirect, regardless of `stall_i`: `if_valid_o <= 0`, go to REQ. The instruction counts as not consumed.
    - `!stall_i`: consumed; `if_valid_o <= 0`, go to REQ.
- Only one memory transaction is ever outstanding. `imem_req_o` is never asserted in WAIT or OUT.

## Timing
- Reset values:
  - State IDLE, `kill_q = 0`, `fetch_pc_q = 0`.
  - `imem_req_o = 0`, `if_valid_o = 0`, `if_pc_o = 0`, `if_instr_o = 0`.
- Signal timing:
  - `nxt_pc_o` and `imem_addr_o` are combinational.
  - `imem_req_o` is decoded from the state register only.
  - `if_*` outputs are registered.
- Best-case throughput with grant in the REQ cycle and `rvalid` in the next cycle:
  - One instruction every 3 cycles (REQ, WAIT, OUT).
  - `if_valid_o` rises 2 cycles after the granted REQ cycle.
- After a redirect, the target is on `imem_addr_o` in the next cycle.
- Reset asserted mid-transaction returns the block to IDLE immediately. A late `rvalid` arriving in IDLE or REQ is ignored.
- `trap_i` and `br_taken_i` together: the trap target wins.

## Test plan
- Reset release, grant immediate, `rvalid` next cycle, data 0x11, 0x22, 0x33 -> ID sees (pc, instr) = (0, 0x11), (4, 0x22), (8, 0x33); `if_valid_o` is high one cycle each.
- `stall_i` high for 4 cycles while presenting pc 4 -> `if_pc_o`/`if_instr_o` hold; `imem_req_o` stays 0; next request is for address 8.
- `br_taken_i` with target 0x40 during WAIT of fetch pc 8 -> the response for 8 is discarded, `if_valid_o` stays 0, next `imem_addr_o` is 0x40, and ID next sees pc 0x40.
- `trap_i` (vector 0x100) and `br_taken_i` (0x40) in the same REQ cycle with a grant -> kill set, next address 0x100, no instruction from the old address reaches ID.
- `pc_i` = 0xFFFFFFFC granted -> `nxt_pc_o` = 0x00000000; `br_target_i` = 0x43 -> `nxt_pc_o` = 0x40.
- Grant withheld 3 cycles -> `imem_req_o` stays high and the address is stable; `rst_ni` pulsed in WAIT -> `imem_req_o` and `if_valid_o` are 0, and the following `rvalid` is ignored.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl : single-outstanding IF-stage fetch sequencer with redirects
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] nxt_pc_o,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_vec_i,
    input  logic                  br_taken_i,
    input  logic [DATA_WIDTH-1:0] br_target_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  stall_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_kill;
    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_if_pc;
    logic [DATA_WIDTH-1:0] r_if_instr;

    logic                  w_redir;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_target;

    assign w_redir = trap_i | br_taken_i;
    assign w_grant = (r_state == S_REQ) & imem_gnt_i;

    always_comb begin
        w_target       = trap_i ? trap_vec_i : br_target_i;
        w_target[1:0]  = 2'b00;
    end

    always_comb begin
        if (w_redir) begin
            nxt_pc_o = w_target;
        end else if (w_grant) begin
            nxt_pc_o = pc_i + DATA_WIDTH'(4);
        end else begin
            nxt_pc_o = pc_i;
        end
    end

    assign imem_addr_o = pc_i;
    assign imem_req_o  = (r_state == S_REQ);
    assign if_valid_o  = r_if_valid;
    assign if_pc_o     = r_if_pc;
    assign if_instr_o  = r_if_instr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_kill     <= 1'b0;
            r_fetch_pc <= '0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    // Without a grant the address may still move on a redirect
                    if (imem_gnt_i) begin
                        r_kill  <= w_redir;
                        r_state <= S_WAIT;
                        if (!w_redir) begin
                            r_fetch_pc <= pc_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redir) begin
                            r_state <= S_REQ;
                        end else begin
                            r_if_instr <= imem_rdata_i;
                            r_if_pc    <= r_fetch_pc;
                            r_if_valid <= 1'b1;
                            r_state    <= S_OUT;
                        end
                    end else if (w_redir) begin
                        r_kill <= 1'b1;
                    end
                end
                S_OUT: begin
                    // A redirect drops the presented instruction even under stall
                    if (w_redir || !stall_i) begin
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl : directed and randomized checks against a program-flow model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic [W-1:0] pc_q;
    logic [W-1:0] nxt_pc;
    logic         trap = 1'b0;
    logic [W-1:0] trap_vec = '0;
    logic         br = 1'b0;
    logic [W-1:0] br_tgt = '0;
    logic         req;
    logic [W-1:0] addr;
    logic         gnt = 1'b0;
    logic         rvalid = 1'b0;
    logic [W-1:0] rdata = '0;
    logic         stall = 1'b0;
    logic         if_valid;
    logic [W-1:0] if_pc;
    logic [W-1:0] if_instr;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.DATA_WIDTH(W)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pc_i         (pc_q),
        .nxt_pc_o     (nxt_pc),
        .trap_i       (trap),
        .trap_vec_i   (trap_vec),
        .br_taken_i   (br),
        .br_target_i  (br_tgt),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .stall_i      (stall),
        .if_valid_o   (if_valid),
        .if_pc_o      (if_pc),
        .if_instr_o   (if_instr)
    );

    // The PC register the controller steers
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) pc_q <= '0;
        else         pc_q <= nxt_pc;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit         g_gnt_en, g_stall, g_br, g_trap;
    logic [31:0] g_br_tgt, g_trap_vec;
    int         g_lat = 1;

    bit          pend, pend_stale;
    logic [31:0] pend_addr;
    int          pend_wait;
    logic [31:0] exp_next;
    bit          prev_valid, prev_stall, prev_redir;
    logic [31:0] prev_pc, prev_instr;
    logic [31:0] last_nxt_pc;

    logic [31:0] pres_pc[$];
    logic [31:0] pres_instr[$];
    int          pres_cyc[$];
    logic [31:0] gnt_addr[$];
    int          gnt_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd12) return ((a >> 2) + 32'd1) * 32'h11;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // One clock: drive at the falling edge, check, then advance the model at the rising edge
    task automatic step();
        bit          redir, c_valid, c_gnt, c_rvalid, c_stall;
        logic [31:0] tgt, exp_nxt, c_pc, c_instr, c_addr;
        gnt      = g_gnt_en && req;
        rvalid   = pend && (pend_wait == 0);
        rdata    = rvalid ? mem_word(pend_addr) : $urandom;
        stall    = g_stall;
        br       = g_br;
        br_tgt   = g_br_tgt;
        trap     = g_trap;
        trap_vec = g_trap_vec;
        #1;
        redir    = trap | br;
        tgt      = trap ? trap_vec : br_tgt;
        tgt      = tgt & 32'hFFFF_FFFC;
        exp_nxt  = redir ? tgt : (gnt ? pc_q + 32'd4 : pc_q);
        last_nxt_pc = nxt_pc;
        c_valid = if_valid; c_pc = if_pc; c_instr = if_instr; c_addr = addr;
        c_gnt = gnt; c_rvalid = rvalid; c_stall = stall;
        checks++;
        if (addr !== pc_q) begin
            errors++; $display("FAIL addr_eq_pc cyc=%0d got=%h want=%h", cyc, addr, pc_q);
        end
        checks++;
        if (nxt_pc !== exp_nxt) begin
            errors++; $display("FAIL nxt_pc cyc=%0d got=%h want=%h", cyc, nxt_pc, exp_nxt);
        end
        if (pend && !pend_stale) begin
            checks++;
            if (req !== 1'b0) begin
                errors++; $display("FAIL single_outstanding cyc=%0d req=%b want=0", cyc, req);
            end
        end
        if (prev_valid && prev_stall && !prev_redir) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         cyc, if_valid, if_pc, if_instr, prev_pc, prev_instr);
            end
        end else if (prev_valid) begin
            checks++;
            if (if_valid !== 1'b0) begin
                errors++; $display("FAIL valid_drop cyc=%0d got=%b want=0", cyc, if_valid);
            end
        end else if (if_valid === 1'b1) begin
            checks += 2;
            if (if_pc !== exp_next) begin
                errors++; $display("FAIL present_pc cyc=%0d got=%h want=%h", cyc, if_pc, exp_next);
            end
            if (if_instr !== mem_word(if_pc)) begin
                errors++;
                $display("FAIL present_instr cyc=%0d got=%h want=%h", cyc, if_instr, mem_word(if_pc));
            end
            pres_pc.push_back(if_pc);
            pres_instr.push_back(if_instr);
            pres_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (redir) exp_next = tgt;
        else if (c_valid && !c_stall) exp_next = c_pc + 32'd4;
        if (c_rvalid) begin
            pend = 1'b0; pend_stale = 1'b0;
        end else if (pend && pend_wait > 0) begin
            pend_wait--;
        end
        if (c_gnt) begin
            pend = 1'b1; pend_addr = c_addr; pend_wait = g_lat - 1;
            gnt_addr.push_back(c_addr);
            gnt_cyc.push_back(cyc);
        end
        prev_valid = c_valid; prev_stall = c_stall; prev_redir = redir;
        prev_pc = c_pc; prev_instr = c_instr;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_model();
        pend = 0; pend_stale = 0; pend_wait = 0; pend_addr = '0;
        exp_next = '0; prev_valid = 0; prev_stall = 0; prev_redir = 0;
        prev_pc = '0; prev_instr = '0;
        g_gnt_en = 1; g_stall = 0; g_br = 0; g_trap = 0;
        g_br_tgt = '0; g_trap_vec = '0; g_lat = 1;
        pres_pc.delete(); pres_instr.delete(); pres_cyc.delete();
        gnt_addr.delete(); gnt_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        gnt = 0; rvalid = 0; br = 0; trap = 0; stall = 0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 4;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", if_valid); end
        if (if_pc !== '0)      begin errors++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
        if (if_instr !== '0)   begin errors++; $display("FAIL rst_if_instr got=%h want=0", if_instr); end
        if (req !== 1'b0)      begin errors++; $display("FAIL rst_req got=%b want=0", req); end
        step();
        checks++;
        if (req !== 1'b1) begin errors++; $display("FAIL idle_to_req req=%b want=1", req); end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (12) step();
        checks++;
        if (pres_pc.size() < 3) begin
            errors++; $display("FAIL basic_count got=%0d want>=3", pres_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks += 2;
                if (pres_pc[i] !== 32'(4 * i)) begin
                    errors++; $display("FAIL basic_pc%0d got=%h want=%h", i, pres_pc[i], 4 * i);
                end
                if (pres_instr[i] !== 32'(17 * (i + 1))) begin
                    errors++; $display("FAIL basic_instr%0d got=%h want=%h", i, pres_instr[i], 17 * (i + 1));
                end
            end
            checks += 2;
            if (pres_cyc[0] - gnt_cyc[0] != 2) begin
                errors++; $display("FAIL basic_latency got=%0d want=2", pres_cyc[0] - gnt_cyc[0]);
            end
            if (pres_cyc[1] - pres_cyc[0] != 3) begin
                errors++; $display("FAIL basic_throughput got=%0d want=3", pres_cyc[1] - pres_cyc[0]);
            end
        end
    endtask

    task automatic test_stall();
        int stall_cnt = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            g_stall = (if_valid === 1'b1) && (if_pc === 32'd4) && (stall_cnt < 4);
            if (g_stall) begin
                stall_cnt++;
                checks++;
                if (req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b want=0", req); end
            end
            step();
        end
        g_stall = 0;
        checks++;
        if (stall_cnt != 4 || gnt_addr.size() < 3 || pres_pc.size() < 2) begin
            errors++;
            $display("FAIL stall_progress stalls=%0d grants=%0d pres=%0d want 4/>=3/>=2",
                     stall_cnt, gnt_addr.size(), pres_pc.size());
        end else begin
            checks += 2;
            if (gnt_addr[2] !== 32'd8) begin
                errors++; $display("FAIL stall_next_addr got=%h want=8", gnt_addr[2]);
            end
            if (gnt_cyc[2] - pres_cyc[1] != 5) begin
                errors++; $display("FAIL stall_resume got=%0d want=5", gnt_cyc[2] - pres_cyc[1]);
            end
        end
    endtask

    task automatic test_branch_wait();
        bit done = 0;
        do_reset();
        g_lat = 2;
        for (int i = 0; i < 30; i++) begin
            g_br = !done && pend && (pend_addr == 32'd8);
            g_br_tgt = 32'h40;
            if (g_br) done = 1;
            step();
        end
        g_br = 0;
        checks++;
        if (!done || pres_pc.size() < 3 || gnt_addr.size() < 4) begin
            errors++; $display("FAIL br_progress done=%0d pres=%0d want 1/>=3", done, pres_pc.size());
        end else begin
            checks += 2;
            if (pres_pc[2] !== 32'h40) begin errors++; $display("FAIL br_pres got=%h want=40", pres_pc[2]); end
            if (gnt_addr[3] !== 32'h40) begin errors++; $display("FAIL br_addr got=%h want=40", gnt_addr[3]); end
            foreach (pres_pc[k]) begin
                checks++;
                if (pres_pc[k] === 32'd8) begin errors++; $display("FAIL br_discard got=%h want!=8", pres_pc[k]); end
            end
        end
    endtask

    task automatic test_trap_vs_branch();
        bit done = 0;
        logic [31:0] seen = '0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            g_trap = !done && (req === 1'b1) && (addr === 32'd8);
            g_br = g_trap; g_trap_vec = 32'h100; g_br_tgt = 32'h40;
            step();
            if (g_trap) begin done = 1; seen = last_nxt_pc; end
            g_trap = 0; g_br = 0;
        end
        checks++;
        if (!done || gnt_addr.size() < 4 || pres_pc.size() < 3) begin
            errors++; $display("FAIL trap_progress done=%0d grants=%0d want 1/>=4", done, gnt_addr.size());
        end else begin
            checks += 3;
            if (seen !== 32'h100) begin errors++; $display("FAIL trap_prio got=%h want=100", seen); end
            if (gnt_addr[3] !== 32'h100) begin errors++; $display("FAIL trap_addr got=%h want=100", gnt_addr[3]); end
            if (pres_pc[2] !== 32'h100) begin errors++; $display("FAIL trap_pres got=%h want=100", pres_pc[2]); end
        end
    endtask

    task automatic test_wrap_align();
        do_reset();
        g_lat = 2; g_gnt_en = 0; g_br = 1; g_br_tgt = 32'hFFFF_FFFC;
        step();
        g_br = 0; g_gnt_en = 1;
        step();
        checks++;
        if (last_nxt_pc !== 32'h0) begin errors++; $display("FAIL wrap got=%h want=0", last_nxt_pc); end
        g_br = 1; g_br_tgt = 32'h43;
        step();
        checks++;
        if (last_nxt_pc !== 32'h40) begin errors++; $display("FAIL align got=%h want=40", last_nxt_pc); end
        g_br = 0;
        for (int i = 0; i < 20 && pres_pc.size() == 0; i++) step();
        checks++;
        if (pres_pc.size() == 0 || pres_pc[0] !== 32'h40) begin
            errors++; $display("FAIL align_pres got=%h want=40", pres_pc.size() ? pres_pc[0] : 32'hx);
        end
    endtask

    task automatic test_withhold_reset();
        do_reset();
        g_gnt_en = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req !== 1'b1 || addr !== 32'h0) begin
                errors++; $display("FAIL withhold%0d req=%b addr=%h want 1/0", i, req, addr);
            end
            step();
        end
        g_gnt_en = 1; g_lat = 4;
        for (int i = 0; i < 40 && gnt_addr.size() < 3; i++) step();
        rst_ni = 1'b0;
        gnt = 0; rvalid = 0;
        #1;
        checks++;
        if (gnt_addr.size() < 3 || req !== 1'b0 || if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
            errors++;
            $display("FAIL rst_mid grants=%0d req=%b v=%b pc=%h want >=3/0/0/0",
                     gnt_addr.size(), req, if_valid, if_pc);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        exp_next = '0; prev_valid = 0; prev_redir = 0; prev_stall = 0;
        pend_stale = 1; pend_wait = 1; g_gnt_en = 0;
        pres_pc.delete(); pres_instr.delete(); pres_cyc.delete();
        repeat (3) step();
        checks++;
        if (if_valid !== 1'b0 || pend) begin
            errors++; $display("FAIL late_rvalid v=%b pend=%0d want 0/0", if_valid, pend);
        end
        g_gnt_en = 1; g_lat = 1;
        for (int i = 0; i < 10 && pres_pc.size() == 0; i++) step();
        checks++;
        if (pres_pc.size() == 0 || pres_pc[0] !== 32'h0 || pres_instr[0] !== 32'h11) begin
            errors++; $display("FAIL post_rst_fetch got=%h want=0", pres_pc.size() ? pres_pc[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            g_gnt_en   = ($urandom % 3) != 0;
            g_lat      = 1 + int'($urandom % 3);
            g_stall    = ($urandom % 4) == 0;
            g_br       = ($urandom % 12) == 0;
            g_br_tgt   = $urandom & 32'h0000_03FF;
            g_trap     = ($urandom % 30) == 0;
            g_trap_vec = 32'h0000_1000 | ($urandom & 32'hFF);
            step();
        end
        g_br = 0; g_trap = 0; g_stall = 0;
        checks++;
        if (pres_pc.size() < 40) begin
            errors++; $display("FAIL random_progress got=%0d want>=40", pres_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch_wait();
        test_trap_vs_branch();
        test_wrap_align();
        test_withhold_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
